// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter generator:
// controller state encoding plus default step and vector constants.
package pc_pkg;

    // Controller states: reset bubble, normal fetch, misaligned-redirect trap.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } pc_state_e;

    localparam int unsigned DEF_XLEN      = 32;
    localparam int unsigned DEF_STEP      = 4;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

endpackage : pc_pkg

// File: rtl/pc_adder.sv
// Fixed-step incrementer for the program counter.
// The sum is truncated to XLEN bits, so the top of the address space wraps to zero.
module pc_adder
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN,
    parameter int unsigned STEP = DEF_STEP
) (
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_sum
);

    // Plain modular add; no carry out is kept.
    assign pc_sum = pc_in + XLEN'(STEP);

endmodule : pc_adder

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage.
//
// Optional feature: define PC_MISALIGN_CHK_EN to trap on redirect targets whose
// low two bits are non-zero. Without it, targets are force-aligned on load,
// the TRAP state is never entered, and misalign/misalign_addr read as zero.
//
// Handshake: pc_actual is offered whenever pc_valid=1; a fetch transfer occurs
// on a rising edge where pc_valid & fetch_ready are both 1, and the PC then
// advances by STEP. A redirect in the same cycle takes priority and the transfer
// is not counted as an advance. pc_actual is stable while pc_valid=1 and
// fetch_ready=0 unless a redirect arrives.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = DEF_XLEN,
    parameter int unsigned     STEP      = DEF_STEP,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_ack,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc_actual,
    output logic [XLEN-1:0] pc_next,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr
);

    pc_state_e state;

    // Link value and sequential successor share one adder.
    pc_adder #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_adder (
        .pc_in  (pc_actual),
        .pc_sum (pc_next)
    );

`ifdef PC_MISALIGN_CHK_EN
    logic            misalign_q;
    logic [XLEN-1:0] misalign_addr_q;

    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;

    // Controller: boot bubble, fetch/redirect in RUN, trap on misaligned target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= BOOT;
            pc_actual       <= RESET_VEC;
            pc_valid        <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN: begin
                    if (redirect) begin
                        if (redirect_target[1:0] != 2'b00) begin
                            // PC is held so the handler sees where fetch stopped.
                            state           <= TRAP;
                            pc_valid        <= 1'b0;
                            misalign_q      <= 1'b1;
                            misalign_addr_q <= redirect_target;
                        end else begin
                            pc_actual <= redirect_target;
                        end
                    end else if (fetch_ready) begin
                        pc_actual <= pc_next;
                    end
                end
                TRAP: begin
                    // misalign_addr is kept for post-mortem until the next trap.
                    if (trap_ack) begin
                        state      <= RUN;
                        pc_valid   <= 1'b1;
                        pc_actual  <= TRAP_VEC;
                        misalign_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end
`else
    // Without the checker, the low target bits and trap_ack have no effect.
    logic unused_inputs;
    assign unused_inputs = ^{trap_ack, redirect_target[1:0], TRAP_VEC};

    assign misalign      = 1'b0;
    assign misalign_addr = '0;

    // Controller: boot bubble, then fetch/redirect with force-aligned targets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc_actual <= RESET_VEC;
            pc_valid  <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN: begin
                    if (redirect) begin
                        pc_actual <= {redirect_target[XLEN-1:2], 2'b00};
                    end else if (fetch_ready) begin
                        pc_actual <= pc_next;
                    end
                end
                default: begin
                    // TRAP is unreachable here; recover into RUN if ever seen.
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
            endcase
        end
    end
`endif

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by random
// traffic, all compared against a behavioural model of the fetch PC.
module tb_pc_gen;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
`ifdef PC_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            fetch_ready = 1'b0;
  logic            redirect = 1'b0;
  logic [XLEN-1:0] redirect_target = '0;
  logic            trap_ack = 1'b0;
  logic            pc_valid;
  logic [XLEN-1:0] pc_actual;
  logic [XLEN-1:0] pc_next;
  logic            misalign;
  logic [XLEN-1:0] misalign_addr;

  pc_gen #(
    .XLEN      (XLEN),
    .STEP      (4),
    .RESET_VEC (RESET_VEC),
    .TRAP_VEC  (TRAP_VEC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_ready     (fetch_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .trap_ack        (trap_ack),
    .pc_valid        (pc_valid),
    .pc_actual       (pc_actual),
    .pc_next         (pc_next),
    .misalign        (misalign),
    .misalign_addr   (misalign_addr)
  );

  // ---------------- reference model ----------------
  // Tracks what fetch should see: whether fetch is live, whether a trap is
  // pending, the address presented, and the last offending target.
  bit          m_booting;
  bit          m_trapped;
  logic [31:0] m_pc;
  logic [31:0] m_bad;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic model_reset();
    m_booting = 1'b1;
    m_trapped = 1'b0;
    m_pc      = RESET_VEC;
    m_bad     = 32'h0;
  endtask

  // One rising edge worth of architectural behaviour.
  task automatic model_edge(input bit fr, input bit rd, input logic [31:0] tgt, input bit ta);
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_trapped) begin
      if (ta) begin
        m_trapped = 1'b0;
        m_pc      = TRAP_VEC;
      end
    end else if (rd) begin
      if (CHK_EN && (tgt % 4 != 0)) begin
        m_trapped = 1'b1;
        m_bad     = tgt;
      end else begin
        m_pc = tgt - (tgt % 4);
      end
    end else if (fr) begin
      m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit live;
    live = !m_booting && !m_trapped;
    chk({tag, ".pc_valid"}, 32'(pc_valid), 32'(live));
    chk({tag, ".pc_actual"}, pc_actual, m_pc);
    chk({tag, ".pc_next"}, pc_next, m_pc + 32'd4);
    chk({tag, ".misalign"}, 32'(misalign), 32'(m_trapped));
    chk({tag, ".misalign_addr"}, misalign_addr, CHK_EN ? m_bad : 32'h0);
  endtask

  // ---------------- driver ----------------
  // Drive at the falling edge, let the rising edge act, check at the next fall.
  task automatic step(input string tag, input bit fr, input bit rd,
                      input logic [31:0] tgt, input bit ta);
    fetch_ready     = fr;
    redirect        = rd;
    redirect_target = tgt;
    trap_ack        = ta;
    @(posedge clk);
    model_edge(fr, rd, tgt, ta);
    @(negedge clk);
    check_all(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] t;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset_hold");
    rst_n = 1'b1;
    check_all("reset_release");

    // Boot bubble, then sequential fetch.
    step("boot", 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step("seq", 1'b1, 1'b0, 32'h0, 1'b0);

    // Stall at 0x10 then release.
    for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall_pc_literal", pc_actual, 32'h10);
    step("release", 1'b1, 1'b0, 32'h0, 1'b0);
    chk("release_pc_literal", pc_actual, 32'h14);

    // Redirect wins over a simultaneous fetch.
    step("redir", 1'b1, 1'b1, 32'h200, 1'b0);
    chk("redir_pc_literal", pc_actual, 32'h200);

    // Misaligned redirect; trap ignores fetch/redirect until acknowledged.
    step("misredir", 1'b1, 1'b1, 32'h202, 1'b0);
    step("trap_hold", 1'b1, 1'b1, 32'h400, 1'b0);
    step("trap_hold2", 1'b1, 1'b0, 32'h0, 1'b0);
    step("trap_ack", 1'b0, 1'b0, 32'h0, 1'b1);
    step("post_ack", 1'b0, 1'b0, 32'h0, 1'b1);

    // Wrap at the top of the address space.
    step("to_top", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step("wrap", 1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_pc_literal", pc_actual, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF0;
      step("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), t,
           ($urandom_range(0, 3) == 0));
    end

    // Leave trap (if any) and enter one again, then reset asynchronously.
    step("pre_rst_ack", 1'b0, 1'b0, 32'h0, 1'b1);
    step("pre_rst_trap", 1'b0, 1'b1, 32'h0000_0303, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    check_all("async_rst_held");
    rst_n = 1'b1;
    step("rst_boot", 1'b1, 1'b0, 32'h0, 1'b0);
    step("rst_run", 1'b1, 1'b0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pc_gen

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RISC-V fetch stage, the registered successor to the combinational PC+4 adder. Holds the current PC, advances it by a configurable step on each accepted fetch, and loads redirect targets from branch/jump resolution. Presents the PC to instruction fetch through a valid/ready handshake, and optionally traps on misaligned redirect targets. Sits between the fetch unit and the execute-stage branch logic.

## Interface
- XLEN, 32, PC width in bits
- STEP, 4, increment applied per accepted fetch (bytes)
- RESET_VEC, 32'h0000_0000, PC loaded by reset (XLEN bits)
- TRAP_VEC, 32'h0000_0100, PC loaded on trap acknowledge (XLEN bits)

- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- fetch_ready  input  1  fetch unit accepts pc_actual this cycle
- redirect  input  1  load redirect_target (branch taken / jump)
- redirect_target  input  XLEN  new PC from execute stage
- trap_ack  input  1  trap handler accepted misalignment; resume at TRAP_VEC
- pc_valid  output  1  pc_actual is a valid fetch address
- pc_actual  output  XLEN  registered current PC
- pc_next  output  XLEN  combinational pc_actual + STEP (link value for JAL/JALR)
- misalign  output  1  misaligned redirect trap pending
- misalign_addr  output  XLEN  offending redirect target

## Operation
- States: BOOT, RUN, TRAP.
- Reset (async, rst_n=0): state BOOT, pc_actual=RESET_VEC, pc_valid=0, misalign=0, misalign_addr=0.
- BOOT: unconditionally -> RUN next cycle; inputs ignored. pc_valid=0.
- RUN: pc_valid=1. Per cycle, in priority order:
  - redirect=1, target aligned: pc_actual <= redirect_target; stay RUN. A simultaneous fetch_ready is not an advance (the in-flight fetch is discarded by fetch).
  - redirect=1, target[1:0]!=0 (macro on): -> TRAP; misalign <= 1; misalign_addr <= redirect_target; pc_actual held.
  - fetch_ready=1: pc_actual <= pc_actual + STEP.
  - else hold.
- TRAP: pc_valid=0; redirect and fetch_ready ignored. trap_ack=1 -> pc_actual <= TRAP_VEC, misalign <= 0, -> RUN. misalign_addr holds last value until the next trap.
- Arithmetic: pc_actual + STEP truncated to XLEN bits; wraps 0xFFFF_FFFC -> 0x0000_0000 with XLEN=32, STEP=4. No overflow flag.
- trap_ack outside TRAP: ignored.

## Timing
- Transfer = pc_valid & fetch_ready on a rising edge.
- Reset release to first pc_valid=1: 1 cycle (BOOT bubble).
- Redirect latency: 1 cycle; target visible on pc_actual the cycle after redirect=1.
- pc_actual stable while pc_valid=1 & fetch_ready=0 unless redirect.
- pc_next purely combinational from pc_actual; no added latency.
- Reset assertion mid-operation (any state) returns to BOOT immediately, outputs to reset values without waiting for clk.

## Configuration
- PC_MISALIGN_CHK_EN defined: redirect targets with bits [1:0] != 0 enter TRAP as above; misalign/misalign_addr live.
- Not defined: redirect_target[1:0] forced to 2'b00 on load; TRAP unreachable; misalign and misalign_addr tied to 0; trap_ack ignored.

## Structure
- Shared package pc_pkg: state enum (BOOT, RUN, TRAP), default STEP and vector constants.
- One sub-module: pc_adder (parametrised XLEN adder, out = in + STEP), instanced for pc_next; increment path reuses pc_next.

## Test plan
- Reset with RESET_VEC=0x0: cycle 0 pc_valid=0, cycle 1 pc_valid=1 pc_actual=0x0; fetch_ready held 1 -> 0x4, 0x8, 0xC on successive cycles; pc_next=pc_actual+4.
- Stall: fetch_ready=0 for 3 cycles at pc_actual=0x10 -> stays 0x10, pc_valid=1; release -> 0x14.
- Redirect with fetch_ready=1 to 0x200 -> next cycle pc_actual=0x200 (not 0x204 nor old+4).
- Misaligned redirect to 0x202 (macro on) -> misalign=1, misalign_addr=0x202, pc_valid=0; trap_ack -> pc_actual=0x100, misalign=0, pc_valid=1. Macro off -> pc_actual=0x200, misalign=0.
- Wrap: pc_actual=0xFFFF_FFFC, fetch_ready=1 -> 0x0000_0000.
- rst_n asserted in TRAP mid-cycle -> immediately pc_actual=RESET_VEC, misalign=0, pc_valid=0; BOOT bubble then RUN.
